// File: rtl/cpu_datapath_sequencer.sv
// cpu_datapath_sequencer
//   Responder side of the control-unit command interface. It generates the
//   one-hot timing sequence T, executes the register, bus, memory and ALU
//   commands on AR, PC, DR, AC, IR and TR, and drives the external memory port.
//
// Ports
//   clk, reset_n              clock and asynchronous active-low reset
//   load_* / clear_* / inc_*  per-register commands (priority clear > load > inc)
//   seq_counter_RESET         next T returns to T0
//   memory_read/memory_write  memory strobes, passed through as mem_rd/mem_wr
//   bus_selectors             bus source: 0 zero, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 mem_rdata
//   alu_enable, alu_mode      AC <= ALU(AC, DR)
//   mem_rdata                 combinational memory read data
//   T                         one-hot timing sequence
//   mem_addr/mem_wdata        AR and the bus
//   *_q, E_flag, Z_flag       architectural state for debug

module cpu_datapath_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_AR,
    input  logic              load_PC,
    input  logic              load_DR,
    input  logic              load_AC,
    input  logic              load_IR,
    input  logic              load_TR,
    input  logic              clear_AR,
    input  logic              clear_PC,
    input  logic              clear_DR,
    input  logic              clear_AC,
    input  logic              clear_TR,
    input  logic              inc_AR,
    input  logic              inc_PC,
    input  logic              inc_DR,
    input  logic              inc_AC,
    input  logic              inc_TR,
    input  logic              seq_counter_RESET,
    input  logic              memory_read,
    input  logic              memory_write,
    input  logic [2:0]        bus_selectors,
    input  logic              alu_enable,
    input  logic [2:0]        alu_mode,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [7:0]        T,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] AR_q,
    output logic [ADDR_W-1:0] PC_q,
    output logic [DATA_W-1:0] DR_q,
    output logic [DATA_W-1:0] AC_q,
    output logic [DATA_W-1:0] IR_q,
    output logic [DATA_W-1:0] TR_q,
    output logic              E_flag,
    output logic              Z_flag
);

    typedef enum logic [2:0] {
        ALU_AND  = 3'd0,
        ALU_OR   = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_SUB  = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_PASS = 3'd5,
        ALU_NOT  = 3'd6,
        ALU_SHL  = 3'd7
    } alu_op_e;

    logic [7:0]        T_q, T_d;
    logic [ADDR_W-1:0] AR_d, PC_d;
    logic [DATA_W-1:0] DR_d, AC_d, IR_d, TR_d;
    logic              E_d, Z_d;

    logic [DATA_W-1:0] bus;
    logic [DATA_W-1:0] alu_res;
    logic              alu_e;
    logic              alu_e_upd;
    logic              alu_z_upd;
    logic [DATA_W:0]   add_ext;
    logic [DATA_W:0]   sub_ext;

    // Bus source, built from pre-edge register contents.
    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        bus = '0;
        unique case (bus_selectors)
            3'd0: bus = '0;
            3'd1: bus = DATA_W'(AR_q);
            3'd2: bus = DATA_W'(PC_q);
            3'd3: bus = DR_q;
            3'd4: bus = AC_q;
            3'd5: bus = IR_q;
            3'd6: bus = TR_q;
            3'd7: bus = mem_rdata;
            default: bus = '0;
        endcase
    end

    // ALU. The extra top bit of add_ext/sub_ext is carry out / borrow.
    always_comb begin
        add_ext   = {1'b0, AC_q} + {1'b0, DR_q};
        sub_ext   = {1'b0, AC_q} - {1'b0, DR_q};
        alu_res   = AC_q;
        alu_e     = E_flag;
        alu_e_upd = 1'b0;
        alu_z_upd = 1'b1;
        unique case (alu_op_e'(alu_mode))
            ALU_AND:  alu_res = AC_q & DR_q;
            ALU_OR:   alu_res = AC_q | DR_q;
            ALU_ADD: begin
                alu_res   = add_ext[DATA_W-1:0];
                alu_e     = add_ext[DATA_W];
                alu_e_upd = 1'b1;
            end
            ALU_SUB: begin
                alu_res   = sub_ext[DATA_W-1:0];
                alu_e     = sub_ext[DATA_W];
                alu_e_upd = 1'b1;
            end
            ALU_XOR:  alu_res = AC_q ^ DR_q;
            ALU_PASS: alu_z_upd = 1'b0;
            ALU_NOT:  alu_res = ~AC_q;
            ALU_SHL: begin
                alu_res   = {AC_q[DATA_W-2:0], 1'b0};
                alu_e     = AC_q[DATA_W-1];
                alu_e_upd = 1'b1;
            end
            default: alu_res = AC_q;
        endcase
    end

    // Next-state logic: per register, clear > load > inc; AC inserts the ALU between load and inc.
    always_comb begin
        T_d = seq_counter_RESET ? 8'h01 : {T_q[6:0], T_q[7]};

        AR_d = AR_q;
        if (clear_AR)     AR_d = '0;
        else if (load_AR) AR_d = ADDR_W'(bus);
        else if (inc_AR)  AR_d = AR_q + ADDR_W'(1);

        PC_d = PC_q;
        if (clear_PC)     PC_d = '0;
        else if (load_PC) PC_d = ADDR_W'(bus);
        else if (inc_PC)  PC_d = PC_q + ADDR_W'(1);

        DR_d = DR_q;
        if (clear_DR)     DR_d = '0;
        else if (load_DR) DR_d = bus;
        else if (inc_DR)  DR_d = DR_q + DATA_W'(1);

        TR_d = TR_q;
        if (clear_TR)     TR_d = '0;
        else if (load_TR) TR_d = bus;
        else if (inc_TR)  TR_d = TR_q + DATA_W'(1);

        IR_d = load_IR ? bus : IR_q;

        // Flags move only when the ALU actually owns AC this cycle.
        AC_d = AC_q;
        E_d  = E_flag;
        Z_d  = Z_flag;
        if (clear_AC) begin
            AC_d = '0;
        end else if (load_AC) begin
            AC_d = bus;
        end else if (alu_enable) begin
            AC_d = alu_res;
            if (alu_e_upd) E_d = alu_e;
            if (alu_z_upd) Z_d = (alu_res == '0);
        end else if (inc_AC) begin
            AC_d = AC_q + DATA_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            T_q    <= 8'h01;
            AR_q   <= '0;
            PC_q   <= '0;
            DR_q   <= '0;
            AC_q   <= '0;
            IR_q   <= '0;
            TR_q   <= '0;
            E_flag <= 1'b0;
            Z_flag <= 1'b0;
        end else begin
            T_q    <= T_d;
            AR_q   <= AR_d;
            PC_q   <= PC_d;
            DR_q   <= DR_d;
            AC_q   <= AC_d;
            IR_q   <= IR_d;
            TR_q   <= TR_d;
            E_flag <= E_d;
            Z_flag <= Z_d;
        end
    end

    assign T         = T_q;
    assign mem_addr  = AR_q;
    assign mem_wdata = bus;
    assign mem_rd    = memory_read;
    // A simultaneous read and write is a protocol error; the read wins.
    assign mem_wr    = memory_write & ~memory_read;

endmodule

// File: tb/tb_cpu_datapath_sequencer.sv
// Testbench for cpu_datapath_sequencer: directed steps from the test plan,
// then random commands, all compared against a register-level reference model.

module tb_cpu_datapath_sequencer;

    localparam int R_AR = 0;
    localparam int R_PC = 1;
    localparam int R_DR = 2;
    localparam int R_AC = 3;
    localparam int R_IR = 4;
    localparam int R_TR = 5;
    // clr/inc bit positions: 0 AR, 1 PC, 2 DR, 3 AC, 4 TR
    localparam int C_TR = 4;

    typedef struct packed {
        logic [5:0] ld;
        logic [4:0] clr;
        logic [4:0] inc;
        logic       seq_rst;
        logic       mrd;
        logic       mwr;
        logic [2:0] sel;
        logic       alu_en;
        logic [2:0] mode;
        logic [7:0] rdata;
    } cmd_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    cmd_t c = '0;

    logic [7:0] T, mem_addr, mem_wdata, AR_q, PC_q, DR_q, AC_q, IR_q, TR_q;
    logic       mem_rd, mem_wr, E_flag, Z_flag;

    // Reference model state
    logic [7:0] m_r [6];
    int         m_tidx;
    logic       m_e, m_z;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    cpu_datapath_sequencer #(.DATA_W(8), .ADDR_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_AR(c.ld[R_AR]), .load_PC(c.ld[R_PC]), .load_DR(c.ld[R_DR]),
        .load_AC(c.ld[R_AC]), .load_IR(c.ld[R_IR]), .load_TR(c.ld[R_TR]),
        .clear_AR(c.clr[0]), .clear_PC(c.clr[1]), .clear_DR(c.clr[2]),
        .clear_AC(c.clr[3]), .clear_TR(c.clr[4]),
        .inc_AR(c.inc[0]), .inc_PC(c.inc[1]), .inc_DR(c.inc[2]),
        .inc_AC(c.inc[3]), .inc_TR(c.inc[4]),
        .seq_counter_RESET(c.seq_rst),
        .memory_read(c.mrd), .memory_write(c.mwr),
        .bus_selectors(c.sel), .alu_enable(c.alu_en), .alu_mode(c.mode),
        .mem_rdata(c.rdata),
        .T(T), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr),
        .AR_q(AR_q), .PC_q(PC_q), .DR_q(DR_q), .AC_q(AC_q), .IR_q(IR_q), .TR_q(TR_q),
        .E_flag(E_flag), .Z_flag(Z_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_bus(input logic [2:0] sel, input logic [7:0] rdata);
        case (sel)
            3'd1:    return m_r[R_AR];
            3'd2:    return m_r[R_PC];
            3'd3:    return m_r[R_DR];
            3'd4:    return m_r[R_AC];
            3'd5:    return m_r[R_IR];
            3'd6:    return m_r[R_TR];
            3'd7:    return rdata;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_r[i] = 8'h00;
        m_tidx = 0;
        m_e = 1'b0;
        m_z = 1'b0;
    endtask

    // One clock edge of the architecture, expressed as arithmetic on integers.
    task automatic model_clock(input cmd_t k);
        logic [7:0] b;
        logic [7:0] nxt [6];
        int a, d, s, res;
        b = model_bus(k.sel, k.rdata);
        for (int i = 0; i < 6; i++) nxt[i] = m_r[i];
        // AR, PC, DR share index between ld and clr/inc
        for (int i = 0; i < 3; i++) begin
            if (k.clr[i])     nxt[i] = 8'h00;
            else if (k.ld[i]) nxt[i] = b;
            else if (k.inc[i]) nxt[i] = 8'((int'(m_r[i]) + 1) % 256);
        end
        if (k.clr[C_TR])      nxt[R_TR] = 8'h00;
        else if (k.ld[R_TR])  nxt[R_TR] = b;
        else if (k.inc[C_TR]) nxt[R_TR] = 8'((int'(m_r[R_TR]) + 1) % 256);
        if (k.ld[R_IR]) nxt[R_IR] = b;

        if (k.clr[3]) begin
            nxt[R_AC] = 8'h00;
        end else if (k.ld[R_AC]) begin
            nxt[R_AC] = b;
        end else if (k.alu_en) begin
            a = int'(m_r[R_AC]);
            d = int'(m_r[R_DR]);
            res = a;
            case (k.mode)
                3'd0: res = a & d;
                3'd1: res = a | d;
                3'd2: begin s = a + d; res = s % 256; m_e = (s > 255); end
                3'd3: begin res = (a - d + 256) % 256; m_e = (a < d); end
                3'd4: res = a ^ d;
                3'd5: res = a;
                3'd6: res = 255 - a;
                3'd7: begin res = (a * 2) % 256; m_e = (a >= 128); end
                default: res = a;
            endcase
            if (k.mode != 3'd5) m_z = (res == 0);
            nxt[R_AC] = 8'(res);
        end else if (k.inc[3]) begin
            nxt[R_AC] = 8'((int'(m_r[R_AC]) + 1) % 256);
        end

        for (int i = 0; i < 6; i++) m_r[i] = nxt[i];
        m_tidx = k.seq_rst ? 0 : (m_tidx + 1) % 8;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".T"},  32'(T),      32'(1) << m_tidx);
        check({tag, ".AR"}, 32'(AR_q),   32'(m_r[R_AR]));
        check({tag, ".PC"}, 32'(PC_q),   32'(m_r[R_PC]));
        check({tag, ".DR"}, 32'(DR_q),   32'(m_r[R_DR]));
        check({tag, ".AC"}, 32'(AC_q),   32'(m_r[R_AC]));
        check({tag, ".IR"}, 32'(IR_q),   32'(m_r[R_IR]));
        check({tag, ".TR"}, 32'(TR_q),   32'(m_r[R_TR]));
        check({tag, ".E"},  32'(E_flag), 32'(m_e));
        check({tag, ".Z"},  32'(Z_flag), 32'(m_z));
    endtask

    // Called 1 time unit after a rising edge: drive, check memory port, clock, check state.
    task automatic step(input string tag, input cmd_t k);
        c = k;
        #1;
        if (k.mrd && k.mwr) $display("protocol note (%s): read and write strobes overlap", tag);
        check({tag, ".mem_addr"},  32'(mem_addr),  32'(m_r[R_AR]));
        check({tag, ".mem_wdata"}, 32'(mem_wdata), 32'(model_bus(k.sel, k.rdata)));
        check({tag, ".mem_rd"},    32'(mem_rd),    32'(k.mrd));
        check({tag, ".mem_wr"},    32'(mem_wr),    32'(k.mwr && !k.mrd));
        @(posedge clk);
        model_clock(k);
        #1;
        check_state(tag);
        c = '0;
    endtask

    // Load one register from mem_rdata through the bus.
    task automatic load_reg(input string tag, input int idx, input logic [7:0] v);
        cmd_t k;
        k = '0;
        k.sel = 3'd7;
        k.rdata = v;
        k.ld[idx] = 1'b1;
        step(tag, k);
    endtask

    initial begin
        cmd_t k;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("rst0");
        reset_n = 1'b1;

        // Reset mid-cycle after loading AC
        load_reg("ld_ac3c", R_AC, 8'h3C);
        check("ac_3c", 32'(AC_q), 32'h3C);
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_state("rst_mid");
        check("rst_mid.T_const", 32'(T), 32'h01);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Sequencer: 9 idle clocks then seq reset at T=0x08
        for (int i = 0; i < 9; i++) step("idle", '0);
        check("seq_wrap", 32'(T), 32'h02);
        step("idle", '0);
        step("idle", '0);
        check("seq_at_t3", 32'(T), 32'h08);
        k = '0; k.seq_rst = 1'b1;
        step("seq_rst", k);
        check("seq_rst_T", 32'(T), 32'h01);

        // Fetch path
        load_reg("ld_pc", R_PC, 8'h10);
        k = '0; k.sel = 3'd2; k.ld[R_AR] = 1'b1;
        step("pc_to_ar", k);
        check("fetch_ar", 32'(AR_q), 32'h10);
        k = '0; k.sel = 3'd7; k.rdata = 8'hA5; k.ld[R_IR] = 1'b1; k.inc[1] = 1'b1; k.mrd = 1'b1;
        step("fetch", k);
        check("fetch_ir", 32'(IR_q), 32'hA5);
        check("fetch_pc", 32'(PC_q), 32'h11);

        // ALU
        load_reg("ld_ac", R_AC, 8'hF0);
        load_reg("ld_dr", R_DR, 8'h20);
        k = '0; k.alu_en = 1'b1; k.mode = 3'd2;
        step("add", k);
        check("add_ac", 32'(AC_q), 32'h10);
        check("add_e", 32'(E_flag), 32'h1);
        check("add_z", 32'(Z_flag), 32'h0);
        load_reg("ld_dr", R_DR, 8'h10);
        k = '0; k.alu_en = 1'b1; k.mode = 3'd3;
        step("sub", k);
        check("sub_ac", 32'(AC_q), 32'h00);
        check("sub_e", 32'(E_flag), 32'h0);
        check("sub_z", 32'(Z_flag), 32'h1);
        load_reg("ld_ac", R_AC, 8'h81);
        k = '0; k.alu_en = 1'b1; k.mode = 3'd7;
        step("shl", k);
        check("shl_ac", 32'(AC_q), 32'h02);
        check("shl_e", 32'(E_flag), 32'h1);

        // Priority: clear beats load and ALU, flags untouched; PC wrap
        k = '0; k.clr[3] = 1'b1; k.ld[R_AC] = 1'b1; k.alu_en = 1'b1; k.mode = 3'd3;
        k.sel = 3'd7; k.rdata = 8'h55;
        step("prio", k);
        check("prio_ac", 32'(AC_q), 32'h00);
        check("prio_e", 32'(E_flag), 32'h1);
        check("prio_z", 32'(Z_flag), 32'h0);
        load_reg("ld_pc", R_PC, 8'hFF);
        k = '0; k.inc[1] = 1'b1;
        step("pc_wrap", k);
        check("pc_wrap_val", 32'(PC_q), 32'h00);

        // Store, then read+write overlap
        load_reg("ld_ac", R_AC, 8'h5A);
        load_reg("ld_ar", R_AR, 8'h22);
        c = '0; c.sel = 3'd4; c.mwr = 1'b1;
        #1;
        check("store_wr", 32'(mem_wr), 32'h1);
        check("store_addr", 32'(mem_addr), 32'h22);
        check("store_wdata", 32'(mem_wdata), 32'h5A);
        c.mrd = 1'b1;
        #1;
        check("rw_wr_suppressed", 32'(mem_wr), 32'h0);
        check("rw_rd", 32'(mem_rd), 32'h1);
        @(posedge clk);
        model_clock(c);
        #1;
        check_state("store");
        c = '0;

        // Random commands
        for (int i = 0; i < 400; i++) begin
            k = '0;
            k.ld      = 6'($urandom) & 6'($urandom) & 6'($urandom);
            k.clr     = 5'($urandom) & 5'($urandom) & 5'($urandom) & 5'($urandom);
            k.inc     = 5'($urandom) & 5'($urandom);
            k.seq_rst = ($urandom_range(0, 15) == 0);
            k.mrd     = ($urandom_range(0, 3) == 0);
            k.mwr     = ($urandom_range(0, 3) == 0);
            k.sel     = 3'($urandom);
            k.alu_en  = ($urandom_range(0, 2) == 0);
            k.mode    = 3'($urandom);
            k.rdata   = 8'($urandom);
            step("rand", k);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Hard time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
